// File: rtl/fwd_operand_reg.sv
// Operand-forwarding select for one EX source operand: picks the youngest matching
// later-stage result (or the register file), flags load-use hazards and captures into ID/EX.
module fwd_operand_reg #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int AW    = 5,
    parameter int CNTW  = 16,
    localparam int SELW = $clog2(NSRC + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [AW-1:0]         rs_addr,
    input  logic [WIDTH-1:0]      rf_data,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*AW-1:0]    src_rd,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_ready,
    output logic                  hazard,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic [CNTW-1:0]       hazard_cnt
);

    logic [NSRC-1:0]  w_match;
    logic             w_found;
    logic             w_ready;
    logic [SELW-1:0]  w_sel;
    logic [WIDTH-1:0] w_value;
    logic             w_hazard;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_sel;
    logic [CNTW-1:0]  r_cnt;

    // Match every source, then walk oldest-to-youngest so the youngest match is left standing.
    // x0 never matches, so the register-file path supplies it and that value is forced to zero.
    always_comb begin
        w_match = '0;
        w_found = 1'b0;
        w_ready = 1'b1;
        w_sel   = '0;
        w_value = (rs_addr == '0) ? '0 : rf_data;
        for (int i = 0; i < NSRC; i++) begin
            w_match[i] = src_valid[i] && (src_rd[i*AW +: AW] == rs_addr) && (rs_addr != '0);
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            w_found = w_match[i] | w_found;
            w_ready = w_match[i] ? src_ready[i] : w_ready;
            w_sel   = w_match[i] ? SELW'(i + 1) : w_sel;
            w_value = w_match[i] ? src_data[i*WIDTH +: WIDTH] : w_value;
        end
        w_hazard = in_valid & w_found & ~w_ready;
    end

    // ID/EX capture register: reset, then flush, then stall, then hazard bubble, then load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (stall) begin
            r_valid <= r_valid;
            r_data  <= r_data;
            r_sel   <= r_sel;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            r_valid <= in_valid;
            r_data  <= w_value;
            r_sel   <= w_sel;
        end
    end

    // Saturating hazard-cycle counter; counts through stall and flush cycles too.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_hazard && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign hazard     = w_hazard;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_sel    = r_sel;
    assign hazard_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_operand_reg.sv
// Self-checking bench for fwd_operand_reg: directed scenarios plus randomized traffic
// checked against a first-match reference model; a CNTW=2 instance covers saturation.
module tb_fwd_operand_reg;

    localparam int W = 32;
    localparam int N = 3;
    localparam int A = 5;
    localparam int S = 2;

    logic            clk;
    logic            reset, stall, flush, in_valid;
    logic [A-1:0]    rs_addr;
    logic [W-1:0]    rf_data;
    logic [N-1:0]    src_valid, src_ready;
    logic [N*A-1:0]  src_rd;
    logic [N*W-1:0]  src_data;
    logic            hazard, out_valid, hazard2, out_valid2;
    logic [W-1:0]    out_data, out_data2;
    logic [S-1:0]    out_sel, out_sel2;
    logic [15:0]     hazard_cnt;
    logic [1:0]      hazard_cnt2;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic         m_found, m_haz;
    int           m_idx;
    logic [W-1:0] m_val;
    int           m_sel;
    logic         e_valid;
    logic [W-1:0] e_data;
    int           e_sel;
    int           e_cnt, e_cnt2;

    fwd_operand_reg #(.WIDTH(W), .NSRC(N), .AW(A), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_addr(rs_addr), .rf_data(rf_data), .src_valid(src_valid), .src_rd(src_rd),
        .src_data(src_data), .src_ready(src_ready), .hazard(hazard), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel), .hazard_cnt(hazard_cnt));

    fwd_operand_reg #(.WIDTH(W), .NSRC(N), .AW(A), .CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs_addr(rs_addr), .rf_data(rf_data), .src_valid(src_valid), .src_rd(src_rd),
        .src_data(src_data), .src_ready(src_ready), .hazard(hazard2), .out_valid(out_valid2),
        .out_data(out_data2), .out_sel(out_sel2), .hazard_cnt(hazard_cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic v, input logic [A-1:0] rd,
                           input logic [W-1:0] d, input logic rdy);
        src_valid[i]        = v;
        src_rd[i*A +: A]    = rd;
        src_data[i*W +: W]  = d;
        src_ready[i]        = rdy;
    endtask

    task automatic clear_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        rs_addr = '0; rf_data = '0; src_valid = '0; src_ready = '0; src_rd = '0; src_data = '0;
    endtask

    // First-match search from the rules: youngest valid writer of rs wins, x0 reads zero.
    task automatic settle();
        #1;
        m_found = 1'b0;
        m_idx   = -1;
        if (rs_addr != 0) begin
            for (int i = 0; i < N; i++) begin
                if (!m_found && src_valid[i] && src_rd[i*A +: A] == rs_addr) begin
                    m_found = 1'b1;
                    m_idx   = i;
                end
            end
        end
        m_val = (rs_addr == 0) ? 32'h0 : (m_found ? src_data[m_idx*W +: W] : rf_data);
        m_sel = m_found ? m_idx + 1 : 0;
        m_haz = in_valid && m_found && !src_ready[m_idx];
    endtask

    task automatic advance();
        if (reset) begin
            e_valid = 1'b0; e_data = '0; e_sel = 0; e_cnt = 0; e_cnt2 = 0;
        end else begin
            if (m_haz) begin
                if (e_cnt < 65535) e_cnt++;
                if (e_cnt2 < 3) e_cnt2++;
            end
            if (flush || (!stall && m_haz)) begin
                e_valid = 1'b0; e_data = '0; e_sel = 0;
            end else if (!stall) begin
                e_valid = in_valid; e_data = m_val; e_sel = m_sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        settle(); advance();
        settle(); advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rs_addr = 5'd7; rf_data = 32'hDEAD_BEEF; in_valid = 1'b1;
        set_src(0, 1'b1, 5'd7, 32'h5555_0000, 1'b0);
        reset = 1'b1;
        settle(); advance();
        settle(); advance();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", out_sel); end
        total++; if (hazard_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", hazard_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        in_valid = 1'b1; rs_addr = 5'd5; rf_data = 32'h11;
        set_src(0, 1'b1, 5'd5, 32'hAA, 1'b1);
        set_src(1, 1'b1, 5'd5, 32'hBB, 1'b1);
        settle();
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL prio_hazard got=%0b want=0", hazard); end
        advance();
        total++; if (out_data !== 32'hAA) begin bad++; $display("FAIL prio_data got=%h want=aa", out_data); end
        total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL prio_sel got=%0d want=1", out_sel); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL prio_valid got=%0b want=1", out_valid); end
        // older source wins once the youngest stops writing; no match falls back to rf
        set_src(0, 1'b0, 5'd5, 32'hAA, 1'b1);
        settle(); advance();
        total++; if (out_data !== 32'hBB || out_sel !== 2'd2) begin bad++; $display("FAIL prio_src1 got=%h/%0d want=bb/2", out_data, out_sel); end
        set_src(1, 1'b1, 5'd6, 32'hBB, 1'b1);
        in_valid = 1'b0;
        settle(); advance();
        total++; if (out_data !== 32'h11 || out_sel !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL prio_rf got=%h/%0d/%0b want=11/0/0", out_data, out_sel, out_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1'b1; rs_addr = 5'd5; rf_data = 32'h11;
        set_src(0, 1'b1, 5'd5, 32'hAA, 1'b0);
        set_src(1, 1'b1, 5'd5, 32'hBB, 1'b1);
        settle();
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%0b want=1", hazard); end
        advance();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL lu_bubble got=%0b/%h want=0/0", out_valid, out_data); end
        total++; if (hazard_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", hazard_cnt); end
        set_src(0, 1'b1, 5'd5, 32'hAA, 1'b1);
        settle();
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b want=0", hazard); end
        advance();
        total++; if (out_data !== 32'hAA || hazard_cnt !== 16'd1) begin bad++; $display("FAIL lu_after got=%h/%0d want=aa/1", out_data, hazard_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        in_valid = 1'b1; rs_addr = 5'd0; rf_data = 32'h77;
        set_src(0, 1'b1, 5'd0, 32'hFF, 1'b0);
        settle();
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL x0_hazard got=%0b want=0", hazard); end
        advance();
        total++; if (out_data !== 32'h0 || out_sel !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL x0_out got=%h/%0d/%0b want=0/0/1", out_data, out_sel, out_valid); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        in_valid = 1'b1; rs_addr = 5'd9; rf_data = 32'h1234;
        settle(); advance();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rs_addr = 5'(c + 1); rf_data = $urandom; in_valid = 1'(c & 1);
            settle(); advance();
            total++; if (out_data !== 32'h1234 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold c=%0d got=%h/%0b want=1234/1", c, out_data, out_valid); end
        end
        flush = 1'b1;
        settle(); advance();
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL stall_flush got=%0b/%h want=0/0", out_valid, out_data); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_saturate();
        int want [6] = '{1, 2, 3, 3, 3, 3};
        do_reset();
        in_valid = 1'b1; rs_addr = 5'd3;
        set_src(2, 1'b1, 5'd3, 32'h99, 1'b0);
        for (int c = 0; c < 6; c++) begin
            settle(); advance();
            total++; if (hazard_cnt2 !== 2'(want[c])) begin bad++; $display("FAIL sat_cnt c=%0d got=%0d want=%0d", c, hazard_cnt2, want[c]); end
        end
        total++; if (hazard_cnt !== 16'd6) begin bad++; $display("FAIL sat_wide got=%0d want=6", hazard_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            rs_addr  = 5'($urandom_range(0, 3));
            rf_data  = $urandom;
            for (int i = 0; i < N; i++)
                set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                        ($urandom_range(0, 3) != 0));
            settle();
            total++; if (hazard !== m_haz) begin bad++; $display("FAIL rnd_hazard c=%0d got=%0b want=%0b", c, hazard, m_haz); end
            advance();
            total++; if (out_valid !== e_valid || out_data !== e_data || out_sel !== 2'(e_sel)) begin
                bad++; $display("FAIL rnd_out c=%0d got=%0b/%h/%0d want=%0b/%h/%0d", c, out_valid, out_data, out_sel, e_valid, e_data, e_sel);
            end
            total++; if (hazard_cnt !== 16'(e_cnt) || hazard_cnt2 !== 2'(e_cnt2)) begin
                bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d want=%0d/%0d", c, hazard_cnt, hazard_cnt2, e_cnt, e_cnt2);
            end
        end
    endtask

    initial begin
        clear_inputs();
        e_valid = 1'b0; e_data = '0; e_sel = 0; e_cnt = 0; e_cnt2 = 0;
        @(posedge clk); #1;
        test_reset();
        test_priority();
        test_load_use();
        test_x0();
        test_stall_flush();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
